// File: rtl/onehot_encoder_stream.sv
// onehot_encoder_stream
// Takes an N-bit request vector over a valid/ready handshake and emits
// the binary index of every set bit as a stream of codes. Each code is
// accepted with its own output handshake, and the final code of a vector
// is flagged with out_last. This is the sequential inverse of a decoder.
//
// Build option: define ONEHOT_ENC_MSB_FIRST_EN to emit the highest index
// first. Without it, the lowest index is emitted first. Ports and timing
// are the same in both builds.
//
// Every output is a flop. The code and last flag for the next cycle are
// worked out from the value pend will hold after the current edge.
module onehot_encoder_stream #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_vec,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_code,
  output logic         out_last,
  output logic         busy
);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t       state;
  logic [N-1:0] pend;
  logic [N-1:0] rest;

  // Returns the index of the set bit that is emitted next from v.
  function automatic logic [W-1:0] pick(input logic [N-1:0] v);
    logic [W-1:0] idx;
    idx = '0;
`ifdef ONEHOT_ENC_MSB_FIRST_EN
    for (int i = 0; i < N; i++) begin
      if (v[i]) idx = W'(i);
    end
`else
    for (int i = N - 1; i >= 0; i--) begin
      if (v[i]) idx = W'(i);
    end
`endif
    return idx;
  endfunction

  // Returns 1 when v has exactly one bit set.
  function automatic logic single(input logic [N-1:0] v);
    return (v != '0) && ((v & (v - N'(1))) == '0);
  endfunction

  // This is the pending vector once the code now on out_code has been taken.
  always_comb begin
    rest = pend & ~(N'(1) << out_code);
  end

  // Handshake state machine with registered stream outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pend      <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_code  <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!in_ready) begin
            in_ready <= 1'b1;
          end else if (in_valid && (in_vec != '0)) begin
            state     <= EMIT;
            pend      <= in_vec;
            in_ready  <= 1'b0;
            out_valid <= 1'b1;
            out_code  <= pick(in_vec);
            out_last  <= single(in_vec);
            busy      <= 1'b1;
          end
        end
        EMIT: begin
          if (out_ready) begin
            if (out_last) begin
              state     <= IDLE;
              pend      <= '0;
              in_ready  <= 1'b1;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              busy      <= 1'b0;
            end else begin
              pend     <= rest;
              out_code <= pick(rest);
              out_last <= single(rest);
            end
          end
        end
        default: begin
          state     <= IDLE;
          pend      <= '0;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_onehot_encoder_stream.sv
// tb_onehot_encoder_stream
// This is a self-checking bench for onehot_encoder_stream with N=4.
// The expected codes come from a reference model. For each accepted vector,
// the model lists the indices of the set bits in emission order. It is
// lowest first, or highest first when ONEHOT_ENC_MSB_FIRST_EN is defined.
module tb_onehot_encoder_stream;

  localparam int N = 4;
  localparam int W = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_vec;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_code;
  logic         out_last;
  logic         busy;

  int passed = 0;
  int total  = 0;

  onehot_encoder_stream #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_vec    (in_vec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_code  (out_code),
    .out_last  (out_last),
    .busy      (busy)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  // Reference model: the index of the k-th code emitted for vector v.
  function automatic logic [W-1:0] kth(input logic [N-1:0] v, input int k);
    int order[$];
    for (int i = 0; i < N; i++) begin
      if (v[i]) begin
`ifdef ONEHOT_ENC_MSB_FIRST_EN
        order.push_front(i);
`else
        order.push_back(i);
`endif
      end
    end
    if (k < order.size()) return W'(order[k]);
    return '0;
  endfunction

  // The observable outputs packed as {out_valid, out_code, out_last, in_ready, busy}.
  function automatic logic [5:0] obs();
    return {out_valid, out_code, out_last, in_ready, busy};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [5:0] exp;
    rst_n = 1'b0; in_valid = 1'b0; in_vec = '0; out_ready = 1'b0;
    #2;
    exp = 6'b0;
    total++;
    if (obs() !== exp) $display("[TB] FAIL reset_async got=%b exp=%b", obs(), exp);
    else passed++;
    tick();
    total++;
    if (obs() !== exp) $display("[TB] FAIL reset_held got=%b exp=%b", obs(), exp);
    else passed++;
    rst_n = 1'b1;
    tick();
    exp = 6'b000010;
    total++;
    if (obs() !== exp) $display("[TB] FAIL reset_release got=%b exp=%b", obs(), exp);
    else passed++;
  endtask

  // Sends one nonzero vector, drains it, and checks every cycle against the model.
  // rnd_ready sets out_ready randomly. stall holds out_ready low for that many
  // cycles first. in_valid and in_vec are given random values during emission.
  task automatic test_vector(input logic [N-1:0] v, input bit rnd_ready, input int stall);
    int cnt, k, st;
    bit done, rdy;
    logic [5:0] exp;
    cnt = $countones(v); k = 0; st = stall; done = 1'b0;
    in_valid = 1'b1; in_vec = v; out_ready = 1'b0;
    tick();
    for (int c = 0; c < 200 && !done; c++) begin
      exp = {1'b1, kth(v, k), (k == cnt - 1), 1'b0, 1'b1};
      total++;
      if (obs() !== exp)
        $display("[TB] FAIL emit vec=%b k=%0d got=%b exp=%b", v, k, obs(), exp);
      else passed++;
      if (st > 0) begin rdy = 1'b0; st--; end
      else rdy = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      out_ready = rdy;
      in_valid  = 1'($urandom_range(0, 1));
      in_vec    = N'($urandom);
      tick();
      if (rdy) begin
        if (k == cnt - 1) done = 1'b1;
        else k++;
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    if (!done) begin
      total++;
      $display("[TB] FAIL emit_timeout vec=%b got=%0d codes exp=%0d", v, k, cnt);
    end
    exp = {1'b0, kth(v, cnt - 1), 1'b0, 1'b1, 1'b0};
    total++;
    if (obs() !== exp) $display("[TB] FAIL drain_idle vec=%b got=%b exp=%b", v, obs(), exp);
    else passed++;
  endtask

  task automatic test_zero_vector();
    in_valid = 1'b1; in_vec = '0;
    tick();
    in_valid = 1'b0;
    total++;
    if ({out_valid, out_last, in_ready, busy} !== 4'b0010)
      $display("[TB] FAIL zero_vec got=%b exp=%b", {out_valid, out_last, in_ready, busy}, 4'b0010);
    else passed++;
    tick();
    total++;
    if ({out_valid, out_last, in_ready, busy} !== 4'b0010)
      $display("[TB] FAIL zero_vec_after got=%b exp=%b", {out_valid, out_last, in_ready, busy}, 4'b0010);
    else passed++;
    test_vector(4'b1000, 1'b0, 0);
  endtask

  task automatic test_reset_mid_emit();
    logic [5:0] exp;
    in_valid = 1'b1; in_vec = 4'b1111; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    exp = {1'b1, kth(4'b1111, 0), 1'b0, 1'b0, 1'b1};
    total++;
    if (obs() !== exp) $display("[TB] FAIL midrst_first got=%b exp=%b", obs(), exp);
    else passed++;
    tick();
    rst_n = 1'b0;
    #1;
    exp = 6'b0;
    total++;
    if (obs() !== exp) $display("[TB] FAIL midrst_async got=%b exp=%b", obs(), exp);
    else passed++;
    tick();
    #2;
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      total++;
      if ({out_valid, in_ready, busy} !== 3'b010)
        $display("[TB] FAIL midrst_after c=%0d got=%b exp=%b", c, {out_valid, in_ready, busy}, 3'b010);
      else passed++;
    end
    out_ready = 1'b0;
    test_vector(4'b0010, 1'b0, 0);
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] v1, v2;
    logic [5:0] exp;
    int k1;
    v1 = 4'b1011; v2 = 4'b0101; k1 = $countones(v1);
    in_valid = 1'b1; in_vec = v1; out_ready = 1'b1;
    tick();
    in_vec = v2;
    repeat (k1) tick();
    exp = {1'b0, kth(v1, k1 - 1), 1'b0, 1'b1, 1'b0};
    total++;
    if (obs() !== exp) $display("[TB] FAIL b2b_gap got=%b exp=%b", obs(), exp);
    else passed++;
    tick();
    in_valid = 1'b0;
    exp = {1'b1, kth(v2, 0), 1'b0, 1'b0, 1'b1};
    total++;
    if (obs() !== exp) $display("[TB] FAIL b2b_second got=%b exp=%b", obs(), exp);
    else passed++;
    repeat ($countones(v2)) tick();
    total++;
    if ({out_valid, in_ready, busy} !== 3'b010)
      $display("[TB] FAIL b2b_drain got=%b exp=%b", {out_valid, in_ready, busy}, 3'b010);
    else passed++;
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [N-1:0] v;
    for (int i = 0; i < 25; i++) begin
      v = N'($urandom_range(1, (1 << N) - 1));
      test_vector(v, 1'b1, int'($urandom_range(0, 2)));
      repeat (int'($urandom_range(0, 2))) tick();
    end
  endtask

  // Runs each scenario in turn and prints the summary line.
  initial begin
    test_reset();
    test_vector(4'b0100, 1'b0, 0);
    test_vector(4'b1011, 1'b0, 0);
    test_vector(4'b0110, 1'b0, 3);
    test_zero_vector();
    test_reset_mid_emit();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
